// File: rtl/rv32cpu_type.sv
`default_nettype none
// ============================================================================
//  Package     : rv32cpu_type
//  Description : Shared types for the rv32 out-of-order core. Holds the
//                common data bus broadcast record and the reservation
//                station entry and operand layouts.
//  Revision    : 1.0  initial release
// ============================================================================
package rv32cpu_type;

  localparam int XLEN         = 32;
  localparam int ROB_IDX_W    = 5;
  localparam int RS_PAYLOAD_W = 32;

  // One CDB broadcast: a finished uop's ROB index and its result.
  typedef struct packed {
    logic                 valid;
    logic [ROB_IDX_W-1:0] rob_id;
    logic [XLEN-1:0]      rd_data;
  } cdb_entry_t;

  // Source operand slot. When rdy is set, val holds the operand and tag is
  // stale. When rdy is clear, tag names the producing ROB entry.
  typedef struct packed {
    logic                 rdy;
    logic [ROB_IDX_W-1:0] tag;
    logic [XLEN-1:0]      val;
  } rs_operand_t;

  typedef struct packed {
    logic                    valid;
    logic [RS_PAYLOAD_W-1:0] payload;
    logic [ROB_IDX_W-1:0]    rob_id;
    rs_operand_t             rs1;
    rs_operand_t             rs2;
  } rs_entry_t;

endpackage
`default_nettype wire

// File: rtl/cdb_tag_match.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_tag_match
//  Description : Compares one producer tag against every CDB broadcast port.
//                Reports a hit and the broadcast data. When several ports
//                match, the lowest port index supplies the data.
//  Ports       : tag     in  ROB_IDX_W         tag being waited on
//                cdb_in  in  cdb_entry_t[N]    CDB broadcasts this cycle
//                hit     out 1                 some valid port carries tag
//                data    out XLEN              data of lowest matching port
//  Revision    : 1.0  initial release
// ============================================================================
module cdb_tag_match
  import rv32cpu_type::*;
#(
  parameter int CDB_PORTS = 2
) (
  input  logic [ROB_IDX_W-1:0] tag,
  input  cdb_entry_t           cdb_in [CDB_PORTS],
  output logic                 hit,
  output logic [XLEN-1:0]      data
);

  // Scan from the highest port down so the lowest matching port is the
  // last one written and therefore wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int p = CDB_PORTS - 1; p >= 0; p--) begin
      if (cdb_in[p].valid && (cdb_in[p].rob_id == tag)) begin
        hit  = 1'b1;
        data = cdb_in[p].rd_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cdb_wakeup_station.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_wakeup_station
//  Description : Reservation station that sits in front of one functional
//                unit. It buffers dispatched uops and snoops all CDB ports
//                for the tags of operands that are still pending. Each cycle
//                it issues the lowest-index uop whose operands are both
//                ready.
//  Ports       : clk, rst              clock, async active-high reset
//                flush                 squash all entries at the edge
//                cdb_in[CDB_PORTS]     CDB broadcasts
//                disp_*                dispatch request and uop contents
//                disp_ready            a free entry exists
//                iss_valid/iss_ready   issue handshake toward the FU
//                iss_*                 selected entry contents
//  Revision    : 1.0  initial release
// ============================================================================
module cdb_wakeup_station
  import rv32cpu_type::*;
#(
  parameter int DEPTH     = 8,
  parameter int CDB_PORTS = 2,
  parameter int PAYLOAD_W = RS_PAYLOAD_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  cdb_entry_t           cdb_in [CDB_PORTS],
  input  logic                 disp_valid,
  output logic                 disp_ready,
  input  logic [PAYLOAD_W-1:0] disp_payload,
  input  logic [ROB_IDX_W-1:0] disp_rob_id,
  input  logic                 disp_rs1_rdy,
  input  logic [ROB_IDX_W-1:0] disp_rs1_tag,
  input  logic [XLEN-1:0]      disp_rs1_val,
  input  logic                 disp_rs2_rdy,
  input  logic [ROB_IDX_W-1:0] disp_rs2_tag,
  input  logic [XLEN-1:0]      disp_rs2_val,
  output logic                 iss_valid,
  input  logic                 iss_ready,
  output logic [PAYLOAD_W-1:0] iss_payload,
  output logic [ROB_IDX_W-1:0] iss_rob_id,
  output logic [XLEN-1:0]      iss_rs1_val,
  output logic [XLEN-1:0]      iss_rs2_val
);

  localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // The entry record has a fixed payload field, so the payload parameter
  // must match it.
  if (PAYLOAD_W != RS_PAYLOAD_W) begin : g_payload_w_check
    $error("cdb_wakeup_station: PAYLOAD_W must equal RS_PAYLOAD_W");
  end

  rs_entry_t          r_entry [DEPTH];

  logic [DEPTH-1:0]   w_free;
  logic [DEPTH-1:0]   w_rdy;
  logic               w_free_any;
  logic               w_iss_any;
  logic [c_IDX_W-1:0] w_free_idx;
  logic [c_IDX_W-1:0] w_iss_idx;

  logic [DEPTH-1:0]   w_wk1_hit;
  logic [DEPTH-1:0]   w_wk2_hit;
  logic [XLEN-1:0]    w_wk1_data [DEPTH];
  logic [XLEN-1:0]    w_wk2_data [DEPTH];

  logic               w_byp1_hit;
  logic               w_byp2_hit;
  logic [XLEN-1:0]    w_byp1_data;
  logic [XLEN-1:0]    w_byp2_data;

  logic               w_disp_fire;
  logic               w_iss_fire;

  // Per-entry status and wakeup comparators. Comparators run on every
  // entry; the sequential block only uses hits of valid, pending operands.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    assign w_free[i] = ~r_entry[i].valid;
    assign w_rdy[i]  = r_entry[i].valid & r_entry[i].rs1.rdy & r_entry[i].rs2.rdy;

    cdb_tag_match #(.CDB_PORTS(CDB_PORTS)) u_wk1 (
      .tag    (r_entry[i].rs1.tag),
      .cdb_in (cdb_in),
      .hit    (w_wk1_hit[i]),
      .data   (w_wk1_data[i])
    );

    cdb_tag_match #(.CDB_PORTS(CDB_PORTS)) u_wk2 (
      .tag    (r_entry[i].rs2.tag),
      .cdb_in (cdb_in),
      .hit    (w_wk2_hit[i]),
      .data   (w_wk2_data[i])
    );
  end

  // Dispatch bypass: catches a broadcast of a pending operand's producer
  // in the same cycle that the operand enters the station.
  cdb_tag_match #(.CDB_PORTS(CDB_PORTS)) u_byp1 (
    .tag    (disp_rs1_tag),
    .cdb_in (cdb_in),
    .hit    (w_byp1_hit),
    .data   (w_byp1_data)
  );

  cdb_tag_match #(.CDB_PORTS(CDB_PORTS)) u_byp2 (
    .tag    (disp_rs2_tag),
    .cdb_in (cdb_in),
    .hit    (w_byp2_hit),
    .data   (w_byp2_data)
  );

  // Two lowest-index priority encoders: one picks the free slot, the other
  // picks the issue slot. Both scan downward so the lowest index wins.
  // With no candidate, the index stays 0. On an empty station the issue
  // outputs then show entry 0.
  always_comb begin
    w_free_any = |w_free;
    w_iss_any  = |w_rdy;
    w_free_idx = '0;
    w_iss_idx  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_free[i]) w_free_idx = i[c_IDX_W-1:0];
      if (w_rdy[i])  w_iss_idx  = i[c_IDX_W-1:0];
    end
  end

  // disp_ready uses only the registered valid bits. A slot freed by this
  // cycle's issue therefore becomes reusable one cycle later.
  assign disp_ready  = w_free_any;
  assign w_disp_fire = disp_valid & w_free_any & ~flush;
  assign w_iss_fire  = w_iss_any & iss_ready & ~flush;

  assign iss_valid   = w_iss_any;
  assign iss_payload = r_entry[w_iss_idx].payload;
  assign iss_rob_id  = r_entry[w_iss_idx].rob_id;
  assign iss_rs1_val = r_entry[w_iss_idx].rs1.val;
  assign iss_rs2_val = r_entry[w_iss_idx].rs2.val;

  // The dispatch target is always an invalid slot. The issue target is
  // always a valid slot. So the two writes never touch the same entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entry[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entry[i].valid <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_entry[i].valid) begin
          if (!r_entry[i].rs1.rdy && w_wk1_hit[i]) begin
            r_entry[i].rs1.rdy <= 1'b1;
            r_entry[i].rs1.val <= w_wk1_data[i];
          end
          if (!r_entry[i].rs2.rdy && w_wk2_hit[i]) begin
            r_entry[i].rs2.rdy <= 1'b1;
            r_entry[i].rs2.val <= w_wk2_data[i];
          end
          if (w_iss_fire && (w_iss_idx == i[c_IDX_W-1:0])) begin
            r_entry[i].valid <= 1'b0;
          end
        end else if (w_disp_fire && (w_free_idx == i[c_IDX_W-1:0])) begin
          r_entry[i].valid   <= 1'b1;
          r_entry[i].payload <= disp_payload;
          r_entry[i].rob_id  <= disp_rob_id;
          r_entry[i].rs1.rdy <= disp_rs1_rdy | w_byp1_hit;
          r_entry[i].rs1.tag <= disp_rs1_tag;
          r_entry[i].rs1.val <= disp_rs1_rdy ? disp_rs1_val : w_byp1_data;
          r_entry[i].rs2.rdy <= disp_rs2_rdy | w_byp2_hit;
          r_entry[i].rs2.tag <= disp_rs2_tag;
          r_entry[i].rs2.val <= disp_rs2_rdy ? disp_rs2_val : w_byp2_data;
        end
      end
    end
  end

endmodule
`default_nettype wire
